// File: rtl/rs_dispatch_unit_pkg.sv
// rs_dispatch_unit_pkg: shared widths, functional-unit codes, buffer occupancy
// states and the packed instruction record used by decode, dispatch and the
// reservation stations.
package rs_dispatch_unit_pkg;

    localparam int numRS                   = 4;
    localparam int funcUnitCodeSize        = 3;
    localparam int instFormatWidth         = 25;
    localparam int opcodeSize              = 12;
    localparam int addressWidth            = 64;
    localparam int instructionCounterWidth = 64;
    localparam int instMinIdWidth          = 7;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int regAccessPatternSize    = 2;
    localparam int bodyWidth               = 84;
    localparam int rsIdxWidth              = $clog2(numRS);

    typedef enum logic [funcUnitCodeSize-1:0] {
        FU_INT = 3'd0,
        FU_MUL = 3'd1,
        FU_MEM = 3'd2,
        FU_BR  = 3'd3
    } fu_type_e;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occupancy_e;

    typedef struct packed {
        logic [instFormatWidth-1:0]          instFormat;
        logic [opcodeSize-1:0]               opcode;
        logic [addressWidth-1:0]             address;
        logic [funcUnitCodeSize-1:0]         funcUnitType;
        logic [instructionCounterWidth-1:0]  majID;
        logic [instMinIdWidth-1:0]           minID;
        logic                                is64Bit;
        logic [PidSize-1:0]                  pid;
        logic [TidSize-1:0]                  tid;
        logic [4*regAccessPatternSize-1:0]   regAccessPatterns;
        logic [3:0]                          isRegs;
        logic [bodyWidth-1:0]                body;
    } inst_t;

    function automatic logic [numRS-1:0] rs_onehot(input logic [rsIdxWidth-1:0] idx);
        return {{(numRS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rs_dispatch_unit_if.sv
// rs_dispatch_unit_if: decode-side instruction handshake plus the
// reservation-station strobe/full bus and shared registered output fields.
//   slave  : the dispatch unit (takes *_i, drives *_o)
//   master : the surrounding decode stage / stations
interface rs_dispatch_unit_if;
    import rs_dispatch_unit_pkg::*;

    logic                                flush_i;
    logic                                enable_i;
    logic                                stall_o;
    logic [instFormatWidth-1:0]          instFormat_i;
    logic [opcodeSize-1:0]               opcode_i;
    logic [addressWidth-1:0]             address_i;
    logic [funcUnitCodeSize-1:0]         funcUnitType_i;
    logic [instructionCounterWidth-1:0]  majID_i;
    logic [instMinIdWidth-1:0]           minID_i;
    logic                                is64Bit_i;
    logic [PidSize-1:0]                  pid_i;
    logic [TidSize-1:0]                  tid_i;
    logic [4*regAccessPatternSize-1:0]   regAccessPatterns_i;
    logic [3:0]                          isRegs_i;
    logic [bodyWidth-1:0]                body_i;
    logic [numRS-1:0]                    isFull_i;
    logic [numRS-1:0]                    enable_o;
    logic [instFormatWidth-1:0]          instFormat_o;
    logic [opcodeSize-1:0]               opcode_o;
    logic [addressWidth-1:0]             address_o;
    logic [funcUnitCodeSize-1:0]         funcUnitType_o;
    logic [instructionCounterWidth-1:0]  majID_o;
    logic [instMinIdWidth-1:0]           minID_o;
    logic                                is64Bit_o;
    logic [PidSize-1:0]                  pid_o;
    logic [TidSize-1:0]                  tid_o;
    logic [4*regAccessPatternSize-1:0]   regAccessPatterns_o;
    logic [3:0]                          isRegs_o;
    logic [bodyWidth-1:0]                body_o;
    logic                                error_o;

    modport slave (
        input  flush_i, enable_i, instFormat_i, opcode_i, address_i, funcUnitType_i,
               majID_i, minID_i, is64Bit_i, pid_i, tid_i, regAccessPatterns_i,
               isRegs_i, body_i, isFull_i,
        output stall_o, enable_o, instFormat_o, opcode_o, address_o, funcUnitType_o,
               majID_o, minID_o, is64Bit_o, pid_o, tid_o, regAccessPatterns_o,
               isRegs_o, body_o, error_o
    );

    modport master (
        output flush_i, enable_i, instFormat_i, opcode_i, address_i, funcUnitType_i,
               majID_i, minID_i, is64Bit_i, pid_i, tid_i, regAccessPatterns_i,
               isRegs_i, body_i, isFull_i,
        input  stall_o, enable_o, instFormat_o, opcode_o, address_o, funcUnitType_o,
               majID_o, minID_o, is64Bit_o, pid_o, tid_o, regAccessPatterns_o,
               isRegs_o, body_o, error_o
    );

endinterface

// File: rtl/rs_dispatch_unit_skid_buffer.sv
// dispatch_skid_buffer: 2-entry in-order FIFO of instructions.
//   clock_i, reset_i (async, active-low); flush/push/pop controls;
//   din in; count (EMPTY/ONE/TWO) and head out.
// The caller never pushes at TWO nor pops at EMPTY.
module dispatch_skid_buffer
    import rs_dispatch_unit_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  inst_t      din,
    output occupancy_e count,
    output inst_t      head
);

    occupancy_e count_nx;
    inst_t      tail;

    always_ff @(posedge clock_i or negedge reset_i)
        if (!reset_i) count <= EMPTY;
        else          count <= count_nx;

    always_comb begin
        count_nx = count;
        if (flush)              count_nx = EMPTY;
        else if (push && !pop)  count_nx = (count == EMPTY) ? ONE : TWO;
        else if (pop && !push)  count_nx = (count == TWO) ? ONE : EMPTY;
    end

    // Payload needs no reset: validity is carried entirely by count.
    always_ff @(posedge clock_i) begin
        if (push) tail <= din;
        if (pop)                          head <= (count == TWO) ? tail : din;
        else if (push && count == EMPTY)  head <= din;
    end

endmodule

// File: rtl/rs_dispatch_unit.sv
// rs_dispatch_unit: buffers decoded instructions and strobes the reservation
// station selected by the head's funcUnitType, in strict program order.
//   clock_i, reset_i (async, active-low), bus (rs_dispatch_unit_if.slave).
//   Optional DISPATCH_STATS_EN adds dispatchCount_o / stallCycles_o (32 bit).
module rs_dispatch_unit
    import rs_dispatch_unit_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_i,
    rs_dispatch_unit_if.slave  bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]        dispatchCount_o,
    output logic [31:0]        stallCycles_o
`endif
);

    occupancy_e            count;
    inst_t                 in_inst, head, out_q;
    logic [rsIdxWidth-1:0] tgt;
    logic [numRS-1:0]      enable_q;
    logic                  error_q, head_valid, legal, blocked, dispatch, drop, push;

    assign in_inst = '{
        instFormat:        bus.instFormat_i,
        opcode:            bus.opcode_i,
        address:           bus.address_i,
        funcUnitType:      bus.funcUnitType_i,
        majID:             bus.majID_i,
        minID:             bus.minID_i,
        is64Bit:           bus.is64Bit_i,
        pid:               bus.pid_i,
        tid:               bus.tid_i,
        regAccessPatterns: bus.regAccessPatterns_i,
        isRegs:            bus.isRegs_i,
        body:              bus.body_i
    };

    assign head_valid = count != EMPTY;
    assign tgt        = head.funcUnitType[rsIdxWidth-1:0];
    assign legal      = head.funcUnitType < funcUnitCodeSize'(numRS);
    assign blocked    = head_valid && legal && bus.isFull_i[tgt];
    // Flush overrides both a dispatch and an illegal-type drop at the same edge.
    assign dispatch   = head_valid && legal && !bus.isFull_i[tgt] && !bus.flush_i;
    assign drop       = head_valid && !legal && !bus.flush_i;
    assign push       = bus.enable_i && count != TWO && !bus.flush_i;
    assign bus.stall_o = count == TWO;

    dispatch_skid_buffer u_buf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush   (bus.flush_i),
        .push    (push),
        .pop     (dispatch || drop),
        .din     (in_inst),
        .count   (count),
        .head    (head)
    );

    always_ff @(posedge clock_i or negedge reset_i)
        if (!reset_i) begin
            enable_q <= '0;
            error_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            enable_q <= dispatch ? rs_onehot(tgt) : '0;
            error_q  <= drop;
            if (dispatch) out_q <= head;
        end

    assign bus.enable_o            = enable_q;
    assign bus.error_o             = error_q;
    assign bus.instFormat_o        = out_q.instFormat;
    assign bus.opcode_o            = out_q.opcode;
    assign bus.address_o           = out_q.address;
    assign bus.funcUnitType_o      = out_q.funcUnitType;
    assign bus.majID_o             = out_q.majID;
    assign bus.minID_o             = out_q.minID;
    assign bus.is64Bit_o           = out_q.is64Bit;
    assign bus.pid_o               = out_q.pid;
    assign bus.tid_o               = out_q.tid;
    assign bus.regAccessPatterns_o = out_q.regAccessPatterns;
    assign bus.isRegs_o            = out_q.isRegs;
    assign bus.body_o              = out_q.body;

`ifdef DISPATCH_STATS_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clock_i or negedge reset_i)
        if (!reset_i) begin
            dispatchCount_o <= '0;
            stallCycles_o   <= '0;
        end else begin
            dispatchCount_o <= dispatchCount_o + 32'(dispatch);
            stallCycles_o   <= stallCycles_o + 32'(blocked);
        end
`endif

endmodule

// File: tb/tb_rs_dispatch_unit.sv
// tb_rs_dispatch_unit: directed scenarios plus random traffic checked against a queue model.
module tb_rs_dispatch_unit;
    import rs_dispatch_unit_pkg::*;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock_i = ~clock_i;

    rs_dispatch_unit_if bus();
`ifdef DISPATCH_STATS_EN
    logic [31:0] dispatchCount_o, stallCycles_o;
`endif

    rs_dispatch_unit dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef DISPATCH_STATS_EN
        ,
        .dispatchCount_o (dispatchCount_o),
        .stallCycles_o   (stallCycles_o)
`endif
    );

    inst_t drv, got_out;
    assign bus.instFormat_i        = drv.instFormat;
    assign bus.opcode_i            = drv.opcode;
    assign bus.address_i           = drv.address;
    assign bus.funcUnitType_i      = drv.funcUnitType;
    assign bus.majID_i             = drv.majID;
    assign bus.minID_i             = drv.minID;
    assign bus.is64Bit_i           = drv.is64Bit;
    assign bus.pid_i               = drv.pid;
    assign bus.tid_i               = drv.tid;
    assign bus.regAccessPatterns_i = drv.regAccessPatterns;
    assign bus.isRegs_i            = drv.isRegs;
    assign bus.body_i              = drv.body;
    assign got_out = '{
        instFormat: bus.instFormat_o, opcode: bus.opcode_o, address: bus.address_o,
        funcUnitType: bus.funcUnitType_o, majID: bus.majID_o, minID: bus.minID_o,
        is64Bit: bus.is64Bit_o, pid: bus.pid_o, tid: bus.tid_o,
        regAccessPatterns: bus.regAccessPatterns_o, isRegs: bus.isRegs_o, body: bus.body_o
    };

    // Reference model: the buffer is just an ordered list of pending instructions.
    inst_t       q[$];
    logic [63:0] strobe_log[$];
    inst_t       exp_out = '0;
    logic [3:0]  exp_en = '0;
    logic        exp_err = 1'b0;
    int          exp_dc = 0, exp_sc = 0;
    int          total = 0, bad = 0, seq = 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic inst_t mk(input logic [2:0] fu);
        inst_t t;
        t.instFormat        = 25'($urandom);
        t.opcode            = 12'($urandom);
        t.address           = {$urandom, $urandom};
        t.funcUnitType      = fu;
        t.majID             = 64'(seq);
        seq++;
        t.minID             = 7'($urandom);
        t.is64Bit           = 1'($urandom);
        t.pid               = 20'($urandom);
        t.tid               = 16'($urandom);
        t.regAccessPatterns = 8'($urandom);
        t.isRegs            = 4'($urandom);
        t.body              = 84'({$urandom, $urandom, $urandom});
        return t;
    endfunction

    function automatic logic busy(input logic [2:0] t);
        logic [3:0] s;
        s = bus.isFull_i >> t;
        return s[0];
    endfunction

    task automatic model_reset();
        q.delete();
        exp_out = '0;
        exp_en  = '0;
        exp_err = 1'b0;
        exp_dc  = 0;
        exp_sc  = 0;
    endtask

    // Advance one edge: predict from the inputs now applied, then compare after the edge.
    task automatic step();
        inst_t h;
        logic  was_full;
        h = '0;
        was_full = (q.size() == 2);
        exp_en  = '0;
        exp_err = 1'b0;
        if (q.size() != 0) begin
            h = q[0];
            if (h.funcUnitType < 3'd4 && busy(h.funcUnitType)) exp_sc++;
        end
        if (bus.flush_i) q.delete();
        else begin
            if (q.size() != 0) begin
                if (h.funcUnitType >= 3'd4) begin
                    exp_err = 1'b1;
                    void'(q.pop_front());
                end else if (!busy(h.funcUnitType)) begin
                    exp_en  = 4'b0001 << h.funcUnitType;
                    exp_out = h;
                    exp_dc++;
                    void'(q.pop_front());
                end
            end
            if (bus.enable_i && !was_full) q.push_back(drv);
        end
        @(posedge clock_i);
        #1;
        if (bus.enable_o != 0) strobe_log.push_back(bus.majID_o);
        check("enable_o", bus.enable_o, exp_en);
        check("error_o", bus.error_o, exp_err);
        check("stall_o", bus.stall_o, q.size() == 2);
        check("fields_o", got_out, exp_out);
`ifdef DISPATCH_STATS_EN
        check("dispatchCount_o", dispatchCount_o, exp_dc);
        check("stallCycles_o", stallCycles_o, exp_sc);
`endif
    endtask

    task automatic cyc(input logic e, input logic f, input logic [3:0] full, input inst_t d);
        bus.enable_i = e;
        bus.flush_i  = f;
        bus.isFull_i = full;
        drv          = d;
        step();
    endtask

    inst_t a, b, c, z, sent;

    initial begin
        drv          = '0;
        bus.enable_i = 1'b0;
        bus.flush_i  = 1'b0;
        bus.isFull_i = '0;
        repeat (2) @(posedge clock_i);
        #1;
        check("rst_enable", bus.enable_o, 4'b0000);
        check("rst_error", bus.error_o, 1'b0);
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_fields", got_out, '0);
        @(negedge clock_i);
        reset_i = 1'b1;

        // single instruction to RS2
        sent = mk(3'd2);
        cyc(1'b1, 1'b0, 4'b0000, sent);
        check("single_no_bypass", bus.enable_o, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000, sent);
        check("single_strobe", bus.enable_o, 4'b0100);
        check("single_fields", got_out, sent);
        cyc(1'b0, 1'b0, 4'b0000, sent);
        check("single_width", bus.enable_o, 4'b0000);

        // back-pressure on RS1
        a = mk(3'd1); b = mk(3'd1); c = mk(3'd1);
        strobe_log.delete();
        cyc(1'b1, 1'b0, 4'b0010, a);
        cyc(1'b1, 1'b0, 4'b0010, b);
        check("bp_stall_high", bus.stall_o, 1'b1);
        cyc(1'b1, 1'b0, 4'b0010, c);
        cyc(1'b1, 1'b0, 4'b0010, c);
        check("bp_no_strobe", bus.enable_o, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0000, c);
        cyc(1'b1, 1'b0, 4'b0000, c);
        cyc(1'b0, 1'b0, 4'b0000, c);
        check("bp_strobe_rs1", bus.enable_o, 4'b0010);
        cyc(1'b0, 1'b0, 4'b0000, c);
        check("bp_count", strobe_log.size(), 3);
        check("bp_order0", strobe_log[0], a.majID);
        check("bp_order1", strobe_log[1], b.majID);
        check("bp_order2", strobe_log[2], c.majID);

        // head-of-line blocking: RS0 full, RS3 free
        a = mk(3'd0); b = mk(3'd3);
        cyc(1'b1, 1'b0, 4'b0001, a);
        cyc(1'b1, 1'b0, 4'b0001, b);
        cyc(1'b0, 1'b0, 4'b0001, b);
        cyc(1'b0, 1'b0, 4'b0001, b);
        check("hol_blocked", bus.enable_o, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000, b);
        check("hol_first_rs0", bus.enable_o, 4'b0001);
        cyc(1'b0, 1'b0, 4'b0000, b);
        check("hol_then_rs3", bus.enable_o, 4'b1000);

        // illegal type then a normal instruction
        z = mk(3'd2);
        cyc(1'b1, 1'b0, 4'b0000, mk(3'd5));
        cyc(1'b1, 1'b0, 4'b0000, z);
        check("illegal_error", bus.error_o, 1'b1);
        check("illegal_no_strobe", bus.enable_o, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000, z);
        check("illegal_error_once", bus.error_o, 1'b0);
        check("after_illegal_strobe", bus.enable_o, 4'b0100);
        check("after_illegal_id", bus.majID_o, z.majID);

        // flush with valid input while two entries are buffered
        cyc(1'b1, 1'b0, 4'b1111, mk(3'd0));
        cyc(1'b1, 1'b0, 4'b1111, mk(3'd1));
        check("flush_pre_stall", bus.stall_o, 1'b1);
        cyc(1'b1, 1'b1, 4'b1111, mk(3'd2));
        check("flush_stall_low", bus.stall_o, 1'b0);
        strobe_log.delete();
        repeat (4) cyc(1'b0, 1'b0, 4'b0000, drv);
        check("flush_no_strobes", strobe_log.size(), 0);

        // async reset while a strobe is visible
        cyc(1'b1, 1'b0, 4'b0000, mk(3'd2));
        cyc(1'b0, 1'b0, 4'b0000, drv);
        check("pre_reset_strobe", bus.enable_o, 4'b0100);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_rst_enable", bus.enable_o, 4'b0000);
        check("async_rst_stall", bus.stall_o, 1'b0);
        check("async_rst_fields", got_out, '0);
        model_reset();
        @(negedge clock_i);
        reset_i = 1'b1;

        // three dispatches with two blocked cycles
        cyc(1'b1, 1'b0, 4'b0010, mk(3'd1));
        cyc(1'b0, 1'b0, 4'b0010, drv);
        cyc(1'b0, 1'b0, 4'b0010, drv);
        cyc(1'b1, 1'b0, 4'b0000, mk(3'd1));
        cyc(1'b1, 1'b0, 4'b0000, mk(3'd2));
        cyc(1'b0, 1'b0, 4'b0000, drv);
`ifdef DISPATCH_STATS_EN
        check("stats_dispatch3", dispatchCount_o, 32'd3);
        check("stats_stall2", stallCycles_o, 32'd2);
`endif

        // random traffic; upstream holds its instruction while stalled
        for (int i = 0; i < 800; i++) begin
            if (!(bus.enable_i && bus.stall_o)) begin
                bus.enable_i = ($urandom_range(0, 3) != 0);
                drv = mk(($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 3))
                                                    : 3'($urandom_range(4, 7)));
            end
            bus.flush_i  = ($urandom_range(0, 29) == 0);
            bus.isFull_i = 4'($urandom) & 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_unit.md
# rs_dispatch_unit

Dispatch-side transmitter for the out-of-order core's reservation stations. Accepts decoded instructions from the decode stage, buffers them in a 2-entry in-order skid buffer, and delivers each one to the reservation station matching its functional-unit type. It drives that station's one-hot `enable_o` strobe and holds off whenever the target station reports `isFull_i`. It sits between the decoders and the bank of reservation stations.

## Interface
- `numRS`, 4: number of reservation stations driven (one per functional-unit type).
- `funcUnitCodeSize`, 3: width of the functional-unit type code.
- `opcodeSize`, 12; `addressWidth`, 64; `instructionCounterWidth`, 64; `instMinIdWidth`, 7: instruction field widths.
- `PidSize`, 20; `TidSize`, 16: process and thread ID widths.
- `regAccessPatternSize`, 2: per-operand read/write pattern width.
- `bodyWidth`, 84: operand body width (4 register operands plus a 64-bit immediate).
- `clock_i`, in, 1: the single clock.
- `reset_i`, in, 1: asynchronous, active-low reset.
- `flush_i`, in, 1: discard all buffered and pending instructions.
- `enable_i`, in, 1: upstream instruction valid.
- `stall_o`, out, 1: buffer full; upstream must hold its instruction.
- Upstream instruction fields, all in: `instFormat_i` (25), `opcode_i` (opcodeSize), `address_i` (addressWidth), `funcUnitType_i` (funcUnitCodeSize), `majID_i` (instructionCounterWidth), `minID_i` (instMinIdWidth), `is64Bit_i` (1), `pid_i` (PidSize), `tid_i` (TidSize), `regAccessPatterns_i` (4*regAccessPatternSize), `isRegs_i` (4), `body_i` (bodyWidth).
- `isFull_i`, in, numRS: per-station full flag. When high, that station must not receive a strobe this cycle.
- `enable_o`, out, numRS: one-hot write strobe to the selected station.
- Downstream instruction fields, out: the same set of fields with the `_o` suffix, shared by all stations and registered.
- `error_o`, out, 1: one-cycle pulse when an instruction with an unroutable `funcUnitType` is dropped.

## Operation
- The buffer holds 0, 1 or 2 entries; this occupancy count is the state (EMPTY, ONE, TWO).
- `stall_o` = (count == TWO). It is decoded from the registered state.
- **Enqueue:** at a rising edge, when `enable_i` is high and `stall_o` is low.
- **Head routing:** the target index equals the head's `funcUnitType`.
- **Illegal type:** if `funcUnitType` ≥ numRS, the head is popped without dispatch and `error_o` pulses.
- **Dispatch:** when the head is valid, its target is legal, and `isFull_i[target]` is low, at the next edge:
  - the output fields load the head's contents;
  - `enable_o` = (1 << target);
  - the head is popped.
- **Otherwise:** `enable_o` = 0 and the output fields hold their previous values.
- **Ordering:** strictly in order. A blocked head blocks the younger entry, even if the younger entry's station is free.
- **Enqueue and pop in the same edge:** the count is unchanged (ONE→ONE). TWO cannot enqueue.
- **Flush:**
  - At the next edge, the count becomes EMPTY and `enable_o` and `error_o` are 0.
  - Flush wins over a simultaneous `enable_i` (the input is dropped) and over a simultaneous dispatch.
- **Reset, including mid-operation:** all outputs 0, count EMPTY, `stall_o` 0, and all statistics counters 0.

## Timing
- **Latency:** an instruction captured at edge N produces `enable_o` high in the cycle after edge N+1, provided its station is not full.
- **Throughput:** one instruction per cycle in steady state.
- **Strobe width:** `enable_o` is high for exactly one cycle per dispatched instruction.
- **No bypass:** there is no bypass from `enable_i` to the outputs.
- **`isFull_i`:** sampled combinationally in the cycle before the dispatch edge. The station must assert it for any cycle in which it cannot accept an instruction at the coming edge.
- **Stall response:** `stall_o` rises in the cycle after the edge that fills the buffer. Upstream must present the same instruction until `stall_o` is low.

## Configuration
- `DISPATCH_STATS_EN`: adds two extra outputs.
  - `dispatchCount_o` (32): increments on every dispatch.
  - `stallCycles_o` (32): increments on every cycle in which the head is valid but its target is full.
  - Both counters wrap at 2^32, clear on reset, and are not cleared by flush.
- Without `DISPATCH_STATS_EN`: neither port nor counter exists, and all other behaviour is identical.

## Structure
- **Shared package** (e.g. `ooo_pkg`):
  - the functional-unit type codes;
  - `numRS`;
  - all field-width constants;
  - a packed instruction struct bundling every instruction field, used by the decoders, this block and the reservation stations.
- **Sub-module:** `dispatch_skid_buffer`, a 2-entry FIFO of the instruction struct with push/pop/flush, a `count` output and head data.

## Test plan
- **Single instruction:** reset, then one instruction with `funcUnitType` = 2 and all `isFull_i` = 0 → `enable_o` = 4'b0100 for exactly one cycle, one cycle after capture, with all `_o` fields equal to the input.
- **Back-pressure:** `isFull_i[1]` held high; three instructions targeting RS1 presented → two are captured, `stall_o` goes high, the third is held. Release `isFull_i[1]` → three strobes `enable_o` = 4'b0010 in order of `majID`.
- **Head-of-line blocking:** head targets full RS0, second entry targets free RS3 → no strobe until `isFull_i[0]` drops, then RS0 is strobed before RS3.
- **Illegal type:** `funcUnitType` = 5 with numRS = 4 → `error_o` pulses once, no `enable_o`, and the following instruction is dispatched normally.
- **Flush with valid input:** `flush_i` and `enable_i` high in the same cycle with 2 entries buffered → count EMPTY, `stall_o` 0, and no strobe ever appears for any of the three instructions.
- **Async reset mid-operation:** `reset_i` driven low between edges while `enable_o` is high → all outputs go to 0 immediately. With `DISPATCH_STATS_EN`, after 3 dispatches and 2 blocked cycles: `dispatchCount_o` = 3, `stallCycles_o` = 2.
